// File: rtl/expr_vec_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// expr_seq_pkg
// Shared definitions for the expression-datapath stimulus sequencer.
// Contents:
//   OPND_W / Y_W / CNT_W / SETTLE_W : bus and counter widths
//   LFSR60_TAPS                    : feedback mask of the operand generator
//   MISR90_POLY                    : feedback polynomial of the signature MISR
//   state_e                        : sequencer FSM states
//   A*_LSB / B*_LSB                : field offsets of a0..b5 inside opnd
//   lfsr60Step()                   : one step of the operand generator
// ---------------------------------------------------------------------------
package expr_seq_pkg;

    localparam int OPND_W   = 60;
    localparam int Y_W      = 90;
    localparam int CNT_W    = 16;
    localparam int SETTLE_W = 8;

    // The x^60+x^59+1 mask 60'h8000000000000001 keeps only bit 0 at 60-bit
    // width, so the step reduces to a left rotation.  A rotation of a
    // nonzero value can never become zero.
    localparam logic [OPND_W-1:0] LFSR60_TAPS = 60'h000_0000_0000_0001;

    // x^90 + x^89 + x^88 + x^87 + 1
    localparam logic [Y_W-1:0] MISR90_POLY = (Y_W'(1) << 89) | (Y_W'(1) << 88)
                                           | (Y_W'(1) << 87) | Y_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRIVE,
        CAPTURE,
        DONE_HOLD
    } state_e;

    // Operand bus layout {a0,a1,a2,a3,a4,a5,b0,b1,b2,b3,b4,b5}, MSB = a0[3]
    localparam int A0_LSB = 56;  // 4 bits
    localparam int A1_LSB = 51;  // 5 bits
    localparam int A2_LSB = 45;  // 6 bits
    localparam int A3_LSB = 41;  // 4 bits
    localparam int A4_LSB = 36;  // 5 bits
    localparam int A5_LSB = 30;  // 6 bits
    localparam int B0_LSB = 26;  // 4 bits
    localparam int B1_LSB = 21;  // 5 bits
    localparam int B2_LSB = 15;  // 6 bits
    localparam int B3_LSB = 11;  // 4 bits
    localparam int B4_LSB = 6;   // 5 bits
    localparam int B5_LSB = 0;   // 6 bits

    function automatic logic [OPND_W-1:0] lfsr60Step(input logic [OPND_W-1:0] s);
        return {s[OPND_W-2:0], 1'b0} ^ (s[OPND_W-1] ? LFSR60_TAPS : '0);
    endfunction

endpackage

// File: rtl/expr_vec_sequencer_if.sv
// ---------------------------------------------------------------------------
// expr_vec_sequencer_if
// Control, operand and result signals between a run controller, the
// sequencer and the expression datapath under test.
//   start/num_vec/seed : run request (sampled only while the sequencer idles)
//   opnd / y_in        : operand vector out, datapath result back
//   busy/done/vec_cnt  : run progress
//   signature/sig_valid: MISR result and its finality flag
// Modports:
//   master : run controller / datapath side
//   slave  : the sequencer
// ---------------------------------------------------------------------------
interface expr_vec_sequencer_if;
    import expr_seq_pkg::*;

    logic              start;
    logic [CNT_W-1:0]  num_vec;
    logic [OPND_W-1:0] seed;
    logic [OPND_W-1:0] opnd;
    logic [Y_W-1:0]    y_in;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  vec_cnt;
    logic [Y_W-1:0]    signature;
    logic              sig_valid;

    modport master (
        output start, num_vec, seed, y_in,
        input  opnd, busy, done, vec_cnt, signature, sig_valid
    );

    modport slave (
        input  start, num_vec, seed, y_in,
        output opnd, busy, done, vec_cnt, signature, sig_valid
    );

endinterface

// File: rtl/expr_vec_sequencer_misr.sv
// ---------------------------------------------------------------------------
// expr_misr
// Multiple-input signature register of configurable width and polynomial.
// Ports:
//   clk, reset : clock, synchronous active-high reset (clears to zero)
//   clr_i      : synchronous clear, has priority over en_i
//   en_i       : fold data_i into the signature this cycle
//   data_i     : parallel input word
//   sig_o      : current signature
// ---------------------------------------------------------------------------
module expr_misr #(
    parameter int               WIDTH = 90,
    parameter logic [WIDTH-1:0] POLY  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] sig_o
);

    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_d;

    // Shift left, reduce by the polynomial when the MSB falls out, then
    // fold the new input word in.
    always_comb begin
        sig_d = sig_q;
        if (clr_i) begin
            sig_d = '0;
        end else if (en_i) begin
            sig_d = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/expr_vec_sequencer.sv
// ---------------------------------------------------------------------------
// expr_vec_sequencer
// Drives pseudo-random operand vectors into a combinational expression
// datapath, holds each for SETTLE cycles, and compresses every result into
// a 90-bit MISR signature.  One signature per run is reported with
// busy/done/sig_valid.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, aborts any run without done
//   bus   : expr_vec_sequencer_if.slave (start/num_vec/seed/y_in in,
//           opnd/busy/done/vec_cnt/signature/sig_valid out)
// Parameters:
//   SETTLE : cycles each vector is held before capture, 1..255
// ---------------------------------------------------------------------------
module expr_vec_sequencer
    import expr_seq_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    expr_vec_sequencer_if.slave  bus
);

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE - 1);

    state_e              state_q,    state_d;
    logic [OPND_W-1:0]   lfsr_q,     lfsr_d;
    logic [OPND_W-1:0]   opnd_q,     opnd_d;
    logic [OPND_W-1:0]   seed_q,     seed_d;
    logic [CNT_W-1:0]    numVec_q,   numVec_d;
    logic [CNT_W-1:0]    vecCnt_q,   vecCnt_d;
    logic [SETTLE_W-1:0] settle_q,   settle_d;
    logic                done_q,     done_d;
    logic                sigValid_q, sigValid_d;

    logic                misrClr;
    logic                misrEn;
    logic [CNT_W-1:0]    cntInc;
    logic [OPND_W-1:0]   lfsrNext;

    assign cntInc   = vecCnt_q + CNT_W'(1);
    assign lfsrNext = lfsr60Step(lfsr_q);

    // Next-state and datapath control.  opnd only follows the generator
    // when a new vector is about to be driven, so it keeps the last vector
    // once the run has finished.
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        opnd_d     = opnd_q;
        seed_d     = seed_q;
        numVec_d   = numVec_q;
        vecCnt_d   = vecCnt_q;
        settle_d   = settle_q;
        done_d     = 1'b0;
        sigValid_d = sigValid_q;
        misrClr    = 1'b0;
        misrEn     = 1'b0;

        case (state_q)
            IDLE, DONE_HOLD: begin
                if (bus.start) begin
                    if (bus.num_vec != '0) begin
                        numVec_d   = bus.num_vec;
                        seed_d     = bus.seed;
                        sigValid_d = 1'b0;
                        state_d    = LOAD;
                    end else begin
                        // Empty run: report an all-zero signature at once
                        done_d     = 1'b1;
                        sigValid_d = 1'b1;
                        vecCnt_d   = '0;
                        misrClr    = 1'b1;
                        state_d    = DONE_HOLD;
                    end
                end
            end

            LOAD: begin
                // A zero seed would lock the generator, so substitute 1
                lfsr_d   = (seed_q == '0) ? OPND_W'(1) : seed_q;
                opnd_d   = (seed_q == '0) ? OPND_W'(1) : seed_q;
                vecCnt_d = '0;
                settle_d = '0;
                misrClr  = 1'b1;
                state_d  = DRIVE;
            end

            DRIVE: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    state_d  = CAPTURE;
                end else begin
                    settle_d = settle_q + SETTLE_W'(1);
                end
            end

            CAPTURE: begin
                misrEn   = 1'b1;
                vecCnt_d = cntInc;
                lfsr_d   = lfsrNext;
                if (cntInc == numVec_q) begin
                    done_d     = 1'b1;
                    sigValid_d = 1'b1;
                    state_d    = DONE_HOLD;
                end else begin
                    opnd_d  = lfsrNext;
                    state_d = DRIVE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            lfsr_q     <= '0;
            opnd_q     <= '0;
            seed_q     <= '0;
            numVec_q   <= '0;
            vecCnt_q   <= '0;
            settle_q   <= '0;
            done_q     <= 1'b0;
            sigValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            opnd_q     <= opnd_d;
            seed_q     <= seed_d;
            numVec_q   <= numVec_d;
            vecCnt_q   <= vecCnt_d;
            settle_q   <= settle_d;
            done_q     <= done_d;
            sigValid_q <= sigValid_d;
        end
    end

    expr_misr #(
        .WIDTH (Y_W),
        .POLY  (MISR90_POLY)
    ) uMisr (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (misrClr),
        .en_i   (misrEn),
        .data_i (bus.y_in),
        .sig_o  (bus.signature)
    );

    assign bus.opnd      = opnd_q;
    assign bus.busy      = (state_q == LOAD) || (state_q == DRIVE) || (state_q == CAPTURE);
    assign bus.done      = done_q;
    assign bus.vec_cnt   = vecCnt_q;
    assign bus.sig_valid = sigValid_q;

endmodule

// File: tb/tb_expr_vec_sequencer.sv
// ---------------------------------------------------------------------------
// tb_expr_vec_sequencer
// Bench for expr_vec_sequencer.  A SETTLE=1 instance is compared every
// cycle against a run-timeline model; a SETTLE=3 instance covers hold time
// and ignored starts.  A stand-in expression datapath closes the loop from
// opnd back to y_in.
// ---------------------------------------------------------------------------
module tb_expr_vec_sequencer;
    import expr_seq_pkg::*;

    localparam int PERIOD1 = 2;  // SETTLE+1 of the main instance
    localparam logic [89:0] TB_POLY = (90'd1 << 89) | (90'd1 << 88) | (90'd1 << 87) | 90'd1;

    logic clk = 1'b0;
    logic reset;
    logic yConst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    expr_vec_sequencer_if bus1 ();
    expr_vec_sequencer_if bus3 ();

    expr_vec_sequencer #(.SETTLE(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    expr_vec_sequencer #(.SETTLE(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3.slave)
    );

    // Stand-in expression datapath: product and xor of the a-side and b-side
    function automatic logic [89:0] exprFn(input logic [59:0] o);
        logic [29:0] aSide;
        logic [29:0] bSide;
        logic [59:0] prod;
        aSide = o[A5_LSB +: 30];
        bSide = o[B5_LSB +: 30];
        prod  = {30'b0, aSide} * {30'b0, bSide};
        return {prod, aSide ^ bSide};
    endfunction

    function automatic logic [89:0] yOf(input logic [59:0] v);
        return yConst ? 90'h1 : exprFn(v);
    endfunction

    // The generator is a rotation, so vector i is the seed rotated left by i
    function automatic logic [59:0] rotl(input logic [59:0] x, input int n);
        int k;
        k = n % 60;
        if (k == 0) return x;
        return (x << k) | (x >> (60 - k));
    endfunction

    // Multiply the signature by x modulo the polynomial, then add the word
    function automatic logic [89:0] misrFold(input logic [89:0] s, input logic [89:0] y);
        logic [89:0] r;
        r = s << 1;
        if (s[89]) r = r ^ TB_POLY;
        return r ^ y;
    endfunction

    assign bus1.y_in = yOf(bus1.opnd);
    assign bus3.y_in = exprFn(bus3.opnd);

    task automatic checkOutput(input string name, input logic [89:0] act, input logic [89:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (time %0t)", name, act, exp, $time);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge; returns one step after the accepting edge
    task automatic applyStimulus(input bit onSettle3, input int n, input logic [59:0] s);
        if (onSettle3) begin
            bus3.start = 1'b1; bus3.num_vec = 16'(n); bus3.seed = s;
        end else begin
            bus1.start = 1'b1; bus1.num_vec = 16'(n); bus1.seed = s;
        end
        @(posedge clk);
        #1;
        bus1.start = 1'b0;
        bus3.start = 1'b0;
    endtask

    // Run-timeline model of the SETTLE=1 instance.  A run accepted at edge
    // k has LOAD at t=1, vector i on the bus from t=2+i*P, its capture at
    // t=1+(i+1)*P, and done at t=2+N*P.
    logic [59:0] expOpnd;
    logic [89:0] expSig;
    logic [15:0] expCnt;
    logic        expBusy, expDone, expValid;
    bit          modelReady = 1'b0;
    int          mT, mN, mFolded, mC, mEnd;
    logic [59:0] mSeed;

    always @(posedge clk) begin
        if (reset) begin
            expOpnd = '0; expSig = '0; expCnt = '0;
            expBusy = 1'b0; expDone = 1'b0; expValid = 1'b0;
            modelReady = 1'b1;
        end else if (modelReady) begin
            expDone = 1'b0;
            if (!expBusy && bus1.start) begin
                if (bus1.num_vec == 16'd0) begin
                    expDone = 1'b1; expValid = 1'b1; expSig = '0; expCnt = '0;
                end else begin
                    mN = int'(bus1.num_vec);
                    mSeed = (bus1.seed == 60'd0) ? 60'h1 : bus1.seed;
                    mT = 1; expBusy = 1'b1; expValid = 1'b0;
                end
            end else if (expBusy) begin
                mT++;
                mEnd = 2 + mN * PERIOD1;
                if (mT == 2) begin
                    expSig = '0;
                    mFolded = 0;
                end
                mC = (mT >= mEnd) ? mN : (mT - 2) / PERIOD1;
                while (mFolded < mC) begin
                    expSig = misrFold(expSig, yOf(rotl(mSeed, mFolded)));
                    mFolded++;
                end
                expCnt  = 16'(mC);
                expOpnd = rotl(mSeed, (mC == mN) ? mN - 1 : mC);
                if (mT == mEnd) begin
                    expBusy = 1'b0; expDone = 1'b1; expValid = 1'b1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison of the main instance against the model
    always @(negedge clk) begin
        if (modelReady) begin
            checkOutput("m.opnd",      90'(bus1.opnd), 90'(expOpnd));
            checkOutput("m.signature", bus1.signature, expSig);
            checkOutput("m.vec_cnt",   90'(bus1.vec_cnt), 90'(expCnt));
            checkOutput("m.busy",      90'(bus1.busy), 90'(expBusy));
            checkOutput("m.done",      90'(bus1.done), 90'(expDone));
            checkOutput("m.sig_valid", 90'(bus1.sig_valid), 90'(expValid));
        end
    end

    // Watchdog keeps the run bounded even if the stimulus stalls
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [59:0] s3;
        logic [63:0] rnd;
        int          doneCount;
        int          lat;
        bit          seen;

        reset = 1'b1; yConst = 1'b1;
        bus1.start = 1'b0; bus1.num_vec = '0; bus1.seed = '0;
        bus3.start = 1'b0; bus3.num_vec = '0; bus3.seed = '0;
        waitCycles(2);
        checkOutput("reset busy",      90'(bus1.busy), 0);
        checkOutput("reset done",      90'(bus1.done), 0);
        checkOutput("reset sig_valid", 90'(bus1.sig_valid), 0);
        checkOutput("reset opnd",      90'(bus1.opnd), 0);
        checkOutput("reset signature", bus1.signature, 0);
        checkOutput("reset vec_cnt",   90'(bus1.vec_cnt), 0);
        reset = 1'b0;
        waitCycles(1);

        // Basic run: seed 1, two vectors, y tied to 1
        applyStimulus(1'b0, 2, 60'h1);
        checkOutput("basic LOAD busy", 90'(bus1.busy), 1);
        waitCycles(1);
        checkOutput("basic opnd0", 90'(bus1.opnd), 90'h1);
        waitCycles(2);
        checkOutput("basic opnd1", 90'(bus1.opnd), 90'h2);
        waitCycles(1);
        checkOutput("basic done early", 90'(bus1.done), 0);
        waitCycles(1);
        checkOutput("basic done",      90'(bus1.done), 1);
        checkOutput("basic signature", bus1.signature, 90'h3);
        checkOutput("basic vec_cnt",   90'(bus1.vec_cnt), 2);
        checkOutput("basic sig_valid", 90'(bus1.sig_valid), 1);
        checkOutput("basic model sig", expSig, 90'h3);
        waitCycles(1);
        checkOutput("basic done pulse", 90'(bus1.done), 0);

        // Zero seed runs from 1
        yConst = 1'b0;
        applyStimulus(1'b0, 1, 60'h0);
        waitCycles(1);
        checkOutput("zero seed opnd", 90'(bus1.opnd), 90'h1);
        waitCycles(3);

        // Bit 59 shifts out into bit 0
        applyStimulus(1'b0, 2, 60'h800000000000000);
        waitCycles(1);
        checkOutput("wrap opnd0", 90'(bus1.opnd), 90'h800000000000000);
        waitCycles(2);
        checkOutput("wrap opnd1", 90'(bus1.opnd), 90'h1);
        checkOutput("wrap model opnd", 90'(expOpnd), 90'h1);
        waitCycles(4);

        // Zero-length run
        applyStimulus(1'b0, 0, 60'h55);
        checkOutput("zlen done",      90'(bus1.done), 1);
        checkOutput("zlen sig_valid", 90'(bus1.sig_valid), 1);
        checkOutput("zlen signature", bus1.signature, 0);
        checkOutput("zlen vec_cnt",   90'(bus1.vec_cnt), 0);
        checkOutput("zlen busy",      90'(bus1.busy), 0);
        checkOutput("zlen opnd hold", 90'(bus1.opnd), 90'h1);
        waitCycles(1);
        checkOutput("zlen done pulse", 90'(bus1.done), 0);
        checkOutput("zlen busy after", 90'(bus1.busy), 0);

        // Reset during the third DRIVE
        applyStimulus(1'b0, 5, 60'h123456789);
        waitCycles(5);
        checkOutput("midrst busy before", 90'(bus1.busy), 1);
        reset = 1'b1;
        waitCycles(1);
        checkOutput("midrst busy",      90'(bus1.busy), 0);
        checkOutput("midrst done",      90'(bus1.done), 0);
        checkOutput("midrst sig_valid", 90'(bus1.sig_valid), 0);
        checkOutput("midrst signature", bus1.signature, 0);
        checkOutput("midrst opnd",      90'(bus1.opnd), 0);
        checkOutput("midrst vec_cnt",   90'(bus1.vec_cnt), 0);
        reset = 1'b0;
        waitCycles(1);

        // SETTLE=3: vector held four cycles, start while busy ignored
        s3 = 60'hF0F0_1234_5678;
        doneCount = 0;
        applyStimulus(1'b1, 1, s3);
        for (int t = 1; t <= 12; t++) begin
            if (t > 1) waitCycles(1);
            if (bus3.done) doneCount++;
            if (t >= 2 && t <= 5) checkOutput("s3 opnd hold", 90'(bus3.opnd), 90'(s3));
            if (t == 5) checkOutput("s3 done early", 90'(bus3.done), 0);
            if (t == 6) begin
                checkOutput("s3 done",      90'(bus3.done), 1);
                checkOutput("s3 signature", bus3.signature, misrFold(90'h0, exprFn(s3)));
                checkOutput("s3 vec_cnt",   90'(bus3.vec_cnt), 1);
            end
            if (t == 3) begin
                bus3.start = 1'b1; bus3.num_vec = 16'd5; bus3.seed = 60'h9;
            end
            if (t == 4) bus3.start = 1'b0;
        end
        checkOutput("s3 done count", 90'(doneCount), 1);
        checkOutput("s3 opnd after", 90'(bus3.opnd), 90'(s3));

        // Randomised traffic, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            rnd = {$urandom, $urandom};
            bus1.start   = ($urandom_range(0, 5) == 0);
            bus1.num_vec = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(1, 7));
            bus1.seed    = ($urandom_range(0, 7) == 0) ? 60'd0 : rnd[59:0];
            reset        = ($urandom_range(0, 299) == 0);
            waitCycles(1);
        end
        bus1.start = 1'b0;
        reset = 1'b1;
        waitCycles(1);
        reset = 1'b0;
        waitCycles(1);

        // Long run through the datapath, then a back-to-back start
        applyStimulus(1'b0, 1000, 60'hABCDE);
        seen = 1'b0;
        lat = 1;
        for (int i = 0; i < 2100 && !seen; i++) begin
            waitCycles(1);
            lat++;
            if (bus1.done) seen = 1'b1;
        end
        checkOutput("e2e done seen",  90'(seen), 1);
        checkOutput("e2e latency",    90'(lat), 2002);
        checkOutput("e2e signature",  bus1.signature, expSig);
        checkOutput("e2e vec_cnt",    90'(bus1.vec_cnt), 1000);
        checkOutput("e2e sig_valid",  90'(bus1.sig_valid), 1);
        applyStimulus(1'b0, 3, 60'h77);
        checkOutput("b2b sig_valid drop", 90'(bus1.sig_valid), 0);
        checkOutput("b2b busy",           90'(bus1.busy), 1);
        waitCycles(10);
        checkOutput("b2b vec_cnt",   90'(bus1.vec_cnt), 3);
        checkOutput("b2b sig_valid", 90'(bus1.sig_valid), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
